// File: rtl/render_pkg.sv
// Shared types and header-field layout for the render command path.
// The scheduler only inspects the operand count; the shape code passes through untouched.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        OPER,
        DRAW,
        DONE
    } state_t;

    localparam int SHAPE_MSB = 7;
    localparam int SHAPE_LSB = 2;
    localparam int NV_MSB    = 1;
    localparam int NV_LSB    = 0;

    localparam logic [5:0] SHAPE_LINE = 6'd0;

    // Operand bytes following a header: two (X,Y) bytes per vertex.
    function automatic logic [2:0] hdr_oper_bytes(input logic [7:0] hdr);
        return {hdr[NV_MSB:NV_LSB], 1'b0};
    endfunction

endpackage

// File: rtl/render_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer moves past the last owner on i_upd.
// A lone requester always wins regardless of the pointer.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_owner_idx,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~i_owner_idx;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/render_scheduler.sv
// Packet scheduler: grants one byte-stream source per packet, forwards the packet
// to the render unit over READING/STATUS, then waits for draw completion or timeout.
module render_scheduler
    import render_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 12
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       req0_valid,
    input  logic [7:0] req0_byte,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_byte,
    output logic       req1_ready,
    output logic       ru_status,
    output logic       ru_reading,
    output logic [7:0] ru_byte,
    input  logic       ru_finish_write,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err_illegal,
    output logic       err_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_grant;
    logic [2:0]      r_rem;
    logic [TO_W-1:0] r_to;
    logic            r_status;
    logic            r_reading;
    logic [7:0]      r_byte;
    logic            r_err_ill;
    logic            r_err_to;

    logic [1:0]      w_arb_gnt;
    logic            w_sel_valid;
    logic [7:0]      w_sel_byte;
    logic            w_take;
    logic            w_accept;
    logic            w_hdr_ok;
    logic            w_fwd;
    logic            w_to_hit;
    logic            w_ill;
    logic            w_tmo;
    logic            w_upd;

    assign w_take      = (r_state == HEADER) || (r_state == OPER);
    assign w_sel_valid = r_grant[1] ? req1_valid : (r_grant[0] & req0_valid);
    assign w_sel_byte  = r_grant[1] ? req1_byte : req0_byte;
    assign w_accept    = w_take && w_sel_valid;
    assign w_hdr_ok    = |w_sel_byte[NV_MSB:NV_LSB];
    assign w_fwd       = w_accept && ((r_state == OPER) || w_hdr_ok);
    assign w_to_hit    = (r_to == TO_LAST);
    // Pointer moves on entry to DONE, while the owner is still known.
    assign w_upd       = (r_state != DONE) && (w_next == DONE);

    assign req0_ready  = w_take && r_grant[0] && req0_valid;
    assign req1_ready  = w_take && r_grant[1] && req1_valid;

    rr_arbiter2 u_arb (
        .i_clk       (ACLK),
        .i_rst       (ARESET),
        .i_req       ({req1_valid, req0_valid}),
        .i_upd       (w_upd),
        .i_owner_idx (r_grant[1]),
        .o_gnt       (w_arb_gnt)
    );

    always_comb begin
        w_next = r_state;
        w_ill  = 1'b0;
        w_tmo  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_arb_gnt) w_next = HEADER;
            end
            HEADER: begin
                if (w_accept) begin
                    w_next = w_hdr_ok ? OPER : DONE;
                    w_ill  = !w_hdr_ok;
                end
            end
            OPER: begin
                if (w_accept && (r_rem == 3'd1)) w_next = DRAW;
            end
            DRAW: begin
                // Finish has priority over a timeout landing on the same cycle.
                if (ru_finish_write) begin
                    w_next = DONE;
                end else if (w_to_hit) begin
                    w_next = DONE;
                    w_tmo  = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_rem     <= 3'd0;
            r_to      <= '0;
            r_status  <= 1'b0;
            r_reading <= 1'b0;
            r_byte    <= 8'h00;
            r_err_ill <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_reading <= w_fwd;
            r_status  <= (w_next == OPER) || (w_next == DRAW);
            r_err_ill <= w_ill;
            r_err_to  <= w_tmo;

            if (w_fwd) r_byte <= w_sel_byte;

            if (r_state == IDLE) begin
                r_grant <= w_arb_gnt;
            end else if (w_next == DONE) begin
                r_grant <= 2'b00;
            end

            if (w_accept && (r_state == HEADER)) begin
                r_rem <= hdr_oper_bytes(w_sel_byte);
            end else if (w_accept && (r_state == OPER)) begin
                r_rem <= r_rem - 3'd1;
            end

            if (r_state == DRAW) begin
                r_to <= r_to + TO_W'(1);
            end else begin
                r_to <= '0;
            end
        end
    end

    assign ru_status   = r_status;
    assign ru_reading  = r_reading;
    assign ru_byte     = r_byte;
    assign grant       = r_grant;
    assign busy        = (r_state != IDLE);
    assign err_illegal = r_err_ill;
    assign err_timeout = r_err_to;

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler: byte scoreboard on the render-unit side,
// grant-order log, and cycle-exact error/status checks.
module tb_render_scheduler;

    logic       ACLK;
    logic       ARESET;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_byte, req1_byte;
    logic       req0_ready, req1_ready;
    logic       ru_status, ru_reading;
    logic [7:0] ru_byte;
    logic       ru_finish_write;
    logic [1:0] grant;
    logic       busy, err_illegal, err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int n_rd  = 0;
    logic [7:0] exp_q[$];
    logic [1:0] gq[$];
    logic [1:0] prev_g = 2'b00;
    bit log_en    = 1'b0;
    bit stop_resp = 1'b0;

    render_scheduler #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .req0_valid      (req0_valid),
        .req0_byte       (req0_byte),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_byte       (req1_byte),
        .req1_ready      (req1_ready),
        .ru_status       (ru_status),
        .ru_reading      (ru_reading),
        .ru_byte         (ru_byte),
        .ru_finish_write (ru_finish_write),
        .grant           (grant),
        .busy            (busy),
        .err_illegal     (err_illegal),
        .err_timeout     (err_timeout)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Render-unit side scoreboard and grant-order log.
    always @(negedge ACLK) begin
        if (ru_reading === 1'b1) begin
            n_rd++;
            chk("status_while_reading", 32'(ru_status), 32'd1);
            if (exp_q.size() == 0) chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
            else chk("ru_byte", 32'(ru_byte), 32'(exp_q.pop_front()));
        end
        if (log_en && grant != 2'b00 && prev_g == 2'b00) gq.push_back(grant);
        prev_g = grant;
    end

    // Offer one byte from a source and hold it until accepted; returns on the
    // falling edge after the accepting clock edge.
    task automatic push(input int src, input logic [7:0] b, input bit fwd);
        int guard = 0;
        if (src == 0) begin req0_valid = 1'b1; req0_byte = b; end
        else          begin req1_valid = 1'b1; req1_byte = b; end
        #1;
        while (((src == 0) ? req0_ready : req1_ready) !== 1'b1 && guard < 400) begin
            @(negedge ACLK); #1;
            guard++;
        end
        if (guard >= 400) chk("ready_wait", 32'd0, 32'd1);
        else if (fwd) exp_q.push_back(b);
        @(negedge ACLK);
        if (src == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    // Called on the first DRAW cycle; finish is sampled at the end of DRAW cycle k.
    task automatic finish_at(input int k);
        repeat (k) @(negedge ACLK);
        chk("status_in_draw", 32'(ru_status), 32'd1);
        ru_finish_write = 1'b1;
        @(negedge ACLK);
        ru_finish_write = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 200) begin @(negedge ACLK); g++; end
        if (g >= 200) chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  32'(grant), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_status"}, 32'(ru_status), 32'd0);
        chk({tag, "_read"},   32'(ru_reading), 32'd0);
        chk({tag, "_byte"},   32'(ru_byte), 32'd0);
        chk({tag, "_eill"},   32'(err_illegal), 32'd0);
        chk({tag, "_eto"},    32'(err_timeout), 32'd0);
        chk({tag, "_rdy0"},   32'(req0_ready), 32'd0);
    endtask

    initial begin
        int rd0;
        ARESET = 1'b1; ru_finish_write = 1'b0;
        req0_valid = 1'b0; req0_byte = 8'h00;
        req1_valid = 1'b0; req1_byte = 8'h00;
        repeat (3) @(negedge ACLK);
        req0_valid = 1'b1; #1;
        chk_all_zero("reset");
        req0_valid = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK);

        // Single line packet, back-to-back bytes.
        rd0 = n_rd;
        push(0, 8'h02, 1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_status", 32'(ru_status), 32'd1);
        push(0, 8'h10, 1); push(0, 8'h20, 1); push(0, 8'h30, 1); push(0, 8'h40, 1);
        finish_at(3);
        #2;
        chk("t1_reads", 32'(n_rd - rd0), 32'd5);
        chk("t1_done_status", 32'(ru_status), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd1);
        chk("t1_done_grant", 32'(grant), 32'd0);
        chk("t1_done_eto", 32'(err_timeout), 32'd0);
        @(negedge ACLK);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Illegal header from source 1; pointer must then favour source 0.
        rd0 = n_rd;
        push(1, 8'h04, 0);
        #2;
        chk("ill_pulse", 32'(err_illegal), 32'd1);
        chk("ill_no_read", 32'(ru_reading), 32'd0);
        chk("ill_status", 32'(ru_status), 32'd0);
        @(negedge ACLK);
        chk("ill_pulse_end", 32'(err_illegal), 32'd0);
        req0_valid = 1'b1; req0_byte = 8'h01;
        req1_valid = 1'b1; req1_byte = 8'h01;
        @(negedge ACLK); #1;
        chk("ill_rr_grant", 32'(grant), 32'h1);
        chk("ill_rdy1_low", 32'(req1_ready), 32'd0);
        push(0, 8'h01, 1); push(0, 8'hA1, 1); push(0, 8'hA2, 1);
        finish_at(1);
        push(1, 8'h01, 1);
        chk("ill_next_grant", 32'(grant), 32'h2);
        push(1, 8'hB1, 1); push(1, 8'hB2, 1);
        finish_at(1);
        wait_idle();
        chk("ill_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("ill_reads", 32'(n_rd - rd0), 32'd6);

        // Both sources continuously valid after reset: strict alternation from source 0.
        ARESET = 1'b1; @(negedge ACLK); ARESET = 1'b0;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 2; s++) begin
                exp_q.push_back(8'h01);
                exp_q.push_back(8'(8'h40 + p * 16 + s * 8));
                exp_q.push_back(8'(8'h41 + p * 16 + s * 8));
            end
        log_en = 1'b1; stop_resp = 1'b0;
        fork
            begin
                while (!stop_resp) begin
                    @(negedge ACLK);
                    ru_finish_write = ru_status && !ru_reading;
                end
                ru_finish_write = 1'b0;
            end
        join_none
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    push(0, 8'h01, 0);
                    push(0, 8'(8'h40 + p * 16), 0);
                    push(0, 8'(8'h41 + p * 16), 0);
                end
            end
            begin
                for (int p = 0; p < 3; p++) begin
                    push(1, 8'h01, 0);
                    push(1, 8'(8'h48 + p * 16), 0);
                    push(1, 8'(8'h49 + p * 16), 0);
                end
            end
        join
        wait_idle();
        stop_resp = 1'b1;
        repeat (2) @(negedge ACLK);
        log_en = 1'b0;
        chk("rr_grant_count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            chk("rr_grant_seq", 32'(gq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        chk("rr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Bubbles: valid 1,0,0,1,... across a 3-vertex packet.
        rd0 = n_rd;
        push(0, 8'h03, 1);
        for (int k = 0; k < 6; k++) begin
            repeat (2) begin
                @(negedge ACLK);
                chk("bub_status", 32'(ru_status), 32'd1);
            end
            push(0, 8'(8'h60 + k), 1);
        end
        finish_at(2);
        #2;
        chk("bub_reads", 32'(n_rd - rd0), 32'd7);
        wait_idle();

        // Timeout with no finish.
        push(0, 8'h01, 1); push(0, 8'h11, 1); push(0, 8'h12, 1);
        for (int i = 1; i < 16; i++) begin
            @(negedge ACLK);
            chk("to_quiet", 32'(err_timeout), 32'd0);
            chk("to_status", 32'(ru_status), 32'd1);
        end
        @(negedge ACLK);
        chk("to_pulse", 32'(err_timeout), 32'd1);
        chk("to_status_drop", 32'(ru_status), 32'd0);
        @(negedge ACLK);
        chk("to_pulse_end", 32'(err_timeout), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);

        // Finish on the timeout cycle wins.
        push(0, 8'h01, 1); push(0, 8'h21, 1); push(0, 8'h22, 1);
        finish_at(15);
        chk("tie_no_err", 32'(err_timeout), 32'd0);
        chk("tie_status", 32'(ru_status), 32'd0);
        @(negedge ACLK);
        chk("tie_no_err2", 32'(err_timeout), 32'd0);
        chk("tie_idle", 32'(busy), 32'd0);

        // Reset in the middle of operands.
        push(0, 8'h02, 1); push(0, 8'h71, 1); push(0, 8'h72, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk_all_zero("midrst");
        ARESET = 1'b0;
        @(negedge ACLK);
        rd0 = n_rd;
        push(0, 8'h01, 1); push(0, 8'h81, 1); push(0, 8'h82, 1);
        finish_at(1);
        chk("post_rst_eto", 32'(err_timeout), 32'd0);
        wait_idle();
        chk("post_rst_reads", 32'(n_rd - rd0), 32'd3);
        chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
